rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one output channel among 4 requesters. Each requester uses a valid/ready handshake.
- Internally it computes a 2-bit select that steers the same 4:1 selection structure as the team's mux_4_1 datapath. The winning beat is captured in a one-entry output register.
- It sits between independent producers and a single downstream consumer. Sustained throughput is 1 beat/cycle when out_ready is held high.

Parameters:
- W, 8, data width per requester.
- CNT_W, 8, width of each per-requester grant counter (optional feature only).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  4  bit i: requester i has a beat.
- in_data  input  4*W  requester i data at [i*W +: W].
- in_ready  output  4  bit i: requester i's beat is accepted this cycle. At most one bit is high.
- out_valid  output  1  output register holds a beat.
- out_data  output  W  registered data.
- out_src  output  2  index of the requester that produced out_data.
- out_ready  input  1  downstream accepts the beat.
- mux_sel  output  2  current combinational select (winner index). Valid only when any in_valid is high, else 0.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_src=0, rr_ptr=0. in_ready goes 0 combinationally while rst=1.
- rr_ptr (2-bit) is the highest-priority index. Search order is rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3, all mod 4 (wraps 3->0).
- Winner w is the first index in search order with in_valid[w]=1. mux_sel=w.
- can_load = !out_valid || out_ready.
- in_ready = (one-hot of w) when (|in_valid && can_load), else 0.
- in_ready depends combinationally on in_valid and out_ready. It never depends on the data.
- Transfer on requester w: in_valid[w] && in_ready[w] at a clk edge. At that edge:
  - out_data <= in_data[w]
  - out_src <= w
  - out_valid <= 1
  - rr_ptr <= w+1 mod 4
- Output drain: out_valid && out_ready with no new transfer in the same cycle gives out_valid <= 0.
- Simultaneous drain and load: the register is overwritten and out_valid stays 1. No bubble.
- Stall: out_valid && !out_ready. out_data and out_src are held stable and in_ready=0.
- Latency: a beat accepted at edge N appears on out_data after edge N. Fixed 1 cycle.
- rr_ptr advances only on a transfer. Idle cycles and stalls leave it unchanged.
- Requester protocol: a requester may deassert in_valid before acceptance. The arbiter does not lock; the winner is recomputed every cycle.
- Fairness: with all 4 requesting continuously and out_ready=1, the grant order is 0,1,2,3,0,... One grant per cycle.
- Reset mid-operation: any pending output beat is discarded (out_valid=0 after the edge). rr_ptr returns to 0.

Optional Feature:
- Macro: ARB_GRANT_CNT_EN.
- Defined: adds output grant_cnt (4*CNT_W). Count i is at [i*CNT_W +: CNT_W].
  - It increments on each transfer from requester i.
  - It saturates at all-ones and never wraps.
  - It is cleared to 0 by rst.
  - Adds input cnt_clr (1). A synchronous clear of all counters wins over a same-cycle increment.
- Not defined: no grant_cnt or cnt_clr ports and no counter logic. All other behaviour is identical.

Test Plan:
- Reset: in_valid=4'b1111, rst=1 for 2 cycles -> in_ready=0; after the edge, out_valid=0, out_data=0, out_src=0.
- Round-robin rotation: in_valid=4'b1111, in_data={8'h33,8'h22,8'h11,8'h00}, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3; out_data 00,11,22,33 repeating; out_valid continuous.
- Stall/hold: out_ready=0 after the first beat (src 0, data 8'h00) for 5 cycles -> out_data stays 8'h00, in_ready=0; when out_ready returns to 1, the next beat is src 1 in the same cycle.
- Sparse/wrap: rr_ptr=3 (after a grant to 2), in_valid=4'b0001 -> mux_sel=0, in_ready=4'b0001; rr_ptr becomes 1.
- Reset mid-stall: out_valid=1, out_ready=0, rst pulse -> out_valid=0 next cycle; the next grant with in_valid=4'b1010 goes to 1.
- Optional (ARB_GRANT_CNT_EN, CNT_W=2): 5 grants to requester 2 -> grant_cnt[2]=3 (saturated); cnt_clr together with a grant -> 0.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: four requesters share one output channel through a round-robin
// arbiter. A 2-bit select drives a 4:1 data mux. The winning beat is captured in a
// one-entry output register.
// Optional feature macro: ARB_GRANT_CNT_EN. It adds the cnt_clr input, the grant_cnt
// output and the CNT_W parameter: one saturating grant counter per requester.
module rr_mux_arbiter #(
    parameter int W = 8
`ifdef ARB_GRANT_CNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         in_valid,
    input  logic [4*W-1:0]     in_data,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
    output logic [1:0]         out_src,
    input  logic               out_ready,
    output logic [1:0]         mux_sel
`ifdef ARB_GRANT_CNT_EN
    ,
    input  logic               cnt_clr,
    output logic [4*CNT_W-1:0] grant_cnt
`endif
);

    // Handshake rules, on every channel: a beat moves when valid and ready are both
    // high at a rising clk edge. in_ready depends only on in_valid, out_ready and
    // internal state, never on data. At most one in_ready bit is high in any cycle.
    // The winner is recomputed every cycle, so a requester may drop valid freely.

    logic [1:0]   rr_ptr;
    logic [1:0]   win;
    logic [1:0]   idx;
    logic         any_valid;
    logic         can_load;
    logic         transfer;
    logic [W-1:0] sel_data;

    assign any_valid = |in_valid;
    assign can_load  = !out_valid || out_ready;

    // Winner search. Scan from the lowest-priority slot to the highest, so the valid
    // index nearest rr_ptr is the last one written and therefore wins.
    always_comb begin
        win = 2'd0;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_ptr + 2'(k);
            if (in_valid[idx]) begin
                win = idx;
            end
        end
    end

    assign mux_sel = any_valid ? win : 2'd0;

    // 4:1 data selection, steered by the arbiter's select.
    always_comb begin
        sel_data = in_data[0 +: W];
        case (mux_sel)
            2'd0:    sel_data = in_data[0*W +: W];
            2'd1:    sel_data = in_data[1*W +: W];
            2'd2:    sel_data = in_data[2*W +: W];
            default: sel_data = in_data[3*W +: W];
        endcase
    end

    // Grant is one-hot on the winner when the output register can take a beat.
    // Held at 0 while reset is asserted.
    always_comb begin
        in_ready = 4'b0000;
        if (!rst && any_valid && can_load) begin
            in_ready = 4'b0001 << mux_sel;
        end
    end

    assign transfer = |in_ready;

    // Output register and priority pointer. A load wins over a drain, so a beat that
    // drains and reloads in the same cycle leaves no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
            rr_ptr    <= 2'd0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= mux_sel;
            rr_ptr    <= mux_sel + 2'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] cnt_q [4];

    for (genvar i = 0; i < 4; i++) begin : g_cnt
        // Per-requester grant counter. It saturates at all-ones, and a clear wins
        // over a same-cycle increment.
        always_ff @(posedge clk) begin
            if (rst || cnt_clr) begin
                cnt_q[i] <= '0;
            end else if (in_ready[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
        assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed steps followed by random traffic. Every cycle is
// checked against a behavioural model of the round-robin arbiter.
module tb_rr_mux_arbiter;

    localparam int W = 8;
`ifdef ARB_GRANT_CNT_EN
    localparam int CNT_W = 2;
`endif

    // clock / reset block
    logic           clk;
    logic           rst;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_ready;
    logic [1:0]     mux_sel;
`ifdef ARB_GRANT_CNT_EN
    logic               cnt_clr;
    logic [4*CNT_W-1:0] grant_cnt;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rr_mux_arbiter #(
        .W(W)
`ifdef ARB_GRANT_CNT_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_src(out_src),
        .out_ready(out_ready),
        .mux_sel(mux_sel)
`ifdef ARB_GRANT_CNT_EN
        ,
        .cnt_clr(cnt_clr),
        .grant_cnt(grant_cnt)
`endif
    );

    // scoreboard and model state
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int           m_ptr    = 0;
    bit           m_valid  = 0;
    logic [W-1:0] m_data   = '0;
    int           m_src    = 0;
    bit           known    = 0;
    int           m_cnt[4] = '{0, 0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle. Checks the combinational outputs against the model, then
    // advances the model across the edge and checks the registered outputs.
    task automatic step();
        int           w;
        bit           found;
        bit           acc;
        logic [3:0]   e_ready;
        logic [1:0]   e_sel;
        logic [W-1:0] e_data;
        logic [W-1:0] q_head;
        bit           clr;
        #1;
        found = 0;
        w = 0;
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_ptr + k) % 4;
            if (!found && in_valid[j]) begin
                found = 1;
                w = j;
            end
        end
        e_sel   = found ? 2'(w) : 2'd0;
        acc     = found && (!m_valid || out_ready) && !rst;
        e_ready = acc ? (4'b0001 << w) : 4'b0000;
        e_data  = in_data[w*W +: W];
`ifdef ARB_GRANT_CNT_EN
        clr = cnt_clr;
`else
        clr = 0;
`endif
        chk("in_ready", 32'(in_ready), 32'(e_ready));
        if (known) chk("mux_sel", 32'(mux_sel), 32'(e_sel));
        if (known && !rst && m_valid && out_ready && exp_q.size() > 0) begin
            q_head = exp_q.pop_front();
            chk("drain_data", 32'(out_data), 32'(q_head));
        end
        @(posedge clk);
        if (rst) begin
            m_valid = 0;
            m_data  = '0;
            m_src   = 0;
            m_ptr   = 0;
            exp_q.delete();
            known   = 1;
        end else if (acc) begin
            m_valid = 1;
            m_data  = e_data;
            m_src   = w;
            m_ptr   = (w + 1) % 4;
            exp_q.push_back(e_data);
        end else if (out_ready) begin
            m_valid = 0;
        end
`ifdef ARB_GRANT_CNT_EN
        if (rst || clr) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else if (acc && m_cnt[w] < (1 << CNT_W) - 1) begin
            m_cnt[w] = m_cnt[w] + 1;
        end
`endif
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_src", 32'(out_src), 32'(m_src));
`ifdef ARB_GRANT_CNT_EN
        for (int i = 0; i < 4; i++) begin
            chk("grant_cnt", 32'(grant_cnt[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
        end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with every requester asking
        rst = 1'b1;
        in_valid = 4'b1111;
        in_data = 32'h33221100;
        out_ready = 1'b1;
`ifdef ARB_GRANT_CNT_EN
        cnt_clr = 1'b0;
`endif
        step();
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        step();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_src", 32'(out_src), 32'h0);

        // Round-robin rotation, one grant per cycle
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] d;
            step();
            d = 8'h11 * 8'(k % 4);
            chk("rot_src", 32'(out_src), 32'(k % 4));
            chk("rot_data", 32'(out_data), 32'(d));
            chk("rot_valid", 32'(out_valid), 32'h1);
        end

        // Stall and hold after a beat from requester 0
        step();
        chk("stall_first_src", 32'(out_src), 32'h0);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_data", 32'(out_data), 32'h00);
            chk("stall_in_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", 32'(in_ready), 32'h2);
        step();
        chk("unstall_src", 32'(out_src), 32'h1);

        // Sparse request with wrap from pointer 3 to index 0
        in_valid = 4'b0100;
        step();
        in_valid = 4'b0001;
        #1;
        chk("wrap_mux_sel", 32'(mux_sel), 32'h0);
        chk("wrap_in_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 4'b1111;
        out_ready = 1'b0;
        #1;
        chk("wrap_ptr_next", 32'(mux_sel), 32'h1);
        step();

        // Reset in the middle of a stall
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        step();
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;
        in_valid = 4'b1010;
        out_ready = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'h2);
        step();
        chk("midrst_src", 32'(out_src), 32'h1);

`ifdef ARB_GRANT_CNT_EN
        // Counter saturation, then a clear together with a grant
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 4'b0100;
        for (int k = 0; k < 5; k++) step();
        chk("cnt2_sat", 32'(grant_cnt[2*CNT_W +: CNT_W]), 32'h3);
        cnt_clr = 1'b1;
        step();
        chk("cnt2_clr", 32'(grant_cnt[2*CNT_W +: CNT_W]), 32'h0);
        cnt_clr = 1'b0;
`endif

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 49) == 0);
            in_valid = 4'($urandom_range(0, 15));
            in_data = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
`ifdef ARB_GRANT_CNT_EN
            cnt_clr = ($urandom_range(0, 19) == 0);
`endif
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
